// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers.
// Used by the key schedule and its S-box sub-module.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY,
        STREAM
    } ks_state_e;

    // Indexed by i/4; entries 1..10 are the AES-128 round constants.
    localparam logic [7:0] AES_RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04,
        8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(
        input logic [31:0] c
    );
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
            gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
            gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
            gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
            gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    endfunction

    function automatic logic [127:0] inv_mix_cols(
        input logic [127:0] k
    );
        return {
            inv_mix_col(k[127:96]),
            inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]),
            inv_mix_col(k[31:0])
        };
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse then affine map.
// Ports: a (8-bit input byte), s (8-bit substituted byte).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] p;
    logic [7:0] inv;

    // a^254 by square-and-multiply: product of a^2, a^4 .. a^128.
    // Zero maps to zero, as the S-box requires.
    always_comb begin
        p   = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        s = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 key expansion into 44-word storage, streamed round NR..0.
// Ports: clk, rst_n; key_load/key_in start expansion; busy and
// keys_ready report status; rk_start begins a stream; rk_valid,
// rk_ready, rk_out, rk_round, rk_last form the round-key handshake.
// Build option AES_INV_KEY_MIXCOL_EN: rounds 1..NR-1 are emitted
// through the inverse column-mix for the equivalent inverse cipher.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_ready,
    input  logic         rk_start,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    localparam int NW = AES_NK * (NR + 1);

    ks_state_e    state;
    ks_state_e    state_nxt;
    logic [5:0]   idx;
    logic [31:0]  w [0:NW-1];

    logic [31:0]  w_prev;
    logic [31:0]  w_old;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_new;

    logic         beat;
    logic         start;
    logic         advance;
    logic         finish;
    logic [3:0]   rd_round;
    logic [5:0]   rd_base;
    logic [127:0] rd_key;
    logic [127:0] rd_xf;

    // Expansion datapath
    assign w_prev = w[idx - 6'd1];
    assign w_old  = w[idx - 6'd4];
    assign w_rot  = {w_prev[23:0], w_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a (w_rot[8*g +: 8]),
            .s (w_sub[8*g +: 8])
        );
    end

    assign w_new = (idx[1:0] == 2'd0)
                 ? w_old ^ w_sub ^ {AES_RCON[idx[5:2]], 24'h0}
                 : w_old ^ w_prev;

    // Stream control; key_load beats rk_start, rk_start beats a beat.
    assign beat    = rk_valid & rk_ready;
    assign start   = rk_start & ~key_load &
                     ((state == READY) | (state == STREAM));
    assign advance = ~key_load & ~start & beat & (rk_round != 4'd0);
    assign finish  = ~key_load & ~start & beat & (rk_round == 4'd0);

    assign rd_round = start ? 4'(NR) : rk_round - 4'd1;
    assign rd_base  = {rd_round, 2'b00};
    assign rd_key   = {w[rd_base],        w[rd_base + 6'd1],
                       w[rd_base + 6'd2], w[rd_base + 6'd3]};

`ifdef AES_INV_KEY_MIXCOL_EN
    assign rd_xf = ((rd_round != 4'd0) && (rd_round != 4'(NR)))
                 ? inv_mix_cols(rd_key)
                 : rd_key;
`else
    assign rd_xf = rd_key;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (key_load) begin
            state_nxt = EXPAND;
        end else begin
            unique case (state)
                EXPAND: if (idx == 6'(NW - 1)) state_nxt = READY;
                READY:  if (rk_start)          state_nxt = STREAM;
                STREAM: if (finish)            state_nxt = READY;
                default: ;
            endcase
        end
    end

    // Status outputs
    always_comb begin
        busy       = (state == EXPAND);
        keys_ready = (state == READY) | (state == STREAM);
        rk_last    = rk_valid & (rk_round == 4'd0);
    end

    // Word index and round-key output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 6'd0;
            rk_valid <= 1'b0;
            rk_out   <= '0;
            rk_round <= 4'd0;
        end else if (key_load) begin
            idx      <= 6'd4;
            rk_valid <= 1'b0;
        end else begin
            if (state == EXPAND) idx <= idx + 6'd1;
            if (start) begin
                rk_valid <= 1'b1;
                rk_round <= 4'(NR);
                rk_out   <= rd_xf;
            end else if (advance) begin
                rk_round <= rk_round - 4'd1;
                rk_out   <= rd_xf;
            end else if (finish) begin
                rk_valid <= 1'b0;
            end
        end
    end

    // Key storage carries no reset; contents are rebuilt on key_load.
    always_ff @(posedge clk) begin
        if (key_load) begin
            w[0] <= key_in[127:96];
            w[1] <= key_in[95:64];
            w[2] <= key_in[63:32];
            w[3] <= key_in[31:0];
        end else if (state == EXPAND) begin
            w[idx] <= w_new;
        end
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench: random keys and handshakes vs a model
// built from the AES key-expansion rules.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         keys_ready;
    logic         rk_start = 1'b0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sb [0:255];
    logic [31:0]  mw [0:43];
    logic [127:0] got_keys [0:10];
    logic [127:0] first_run [0:10];

    aes_inv_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_in     (key_in),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rk_start   (rk_start),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_out     (rk_out),
        .rk_round   (rk_round),
        .rk_last    (rk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] c;
        logic [7:0] inv;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [7:0]  rc;
        logic [31:0] t;
        for (int j = 0; j < 4; j++) mw[j] = k[127-32*j -: 32];
        rc = 8'h01;
        for (int j = 4; j < 44; j++) begin
            t = mw[j-1];
            if (j % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
                  ^ {rc, 24'h0};
                rc = xt(rc);
            end
            mw[j] = mw[j-4] ^ t;
        end
    endtask

    function automatic logic [127:0] imix(input logic [127:0] k);
        logic [127:0] o;
        logic [7:0]   a [0:3];
        logic [7:0]   m [0:3];
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = k[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] =
                    mul(a[r], m[0]) ^ mul(a[(r+1)%4], m[1]) ^
                    mul(a[(r+2)%4], m[2]) ^ mul(a[(r+3)%4], m[3]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mk(input int r);
        logic [127:0] k;
        k = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
`ifdef AES_INV_KEY_MIXCOL_EN
        if (r > 0 && r < 10) k = imix(k);
`endif
        return k;
    endfunction

    task automatic load_wait(input logic [127:0] k, input bit poke);
        int n;
        model_expand(k);
        key_in = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        rk_start = 1'b0;
        rk_ready = 1'b0;
        n = 1;
        chk("load_busy", busy, 1);
        chk("load_keys_ready", keys_ready, 0);
        chk("load_valid", rk_valid, 0);
        while (!keys_ready && n < 100) begin
            rk_start = poke && (n == 10);
            @(posedge clk); #1;
            n++;
            if (poke && n == 11) chk("start_in_expand", rk_valid, 0);
        end
        rk_start = 1'b0;
        chk("ready_latency", n, 41);
        chk("busy_done", busy, 0);
        chk("idle_valid", rk_valid, 0);
    endtask

    task automatic run_stream(input bit rnd);
        int           beats;
        int           cyc;
        int           er;
        bit           held;
        bit           rdy;
        logic [127:0] h_out;
        logic [3:0]   h_rnd;
        logic         h_last;
        beats = 0;
        cyc = 0;
        held = 1'b0;
        rk_start = 1'b1;
        @(posedge clk); #1;
        rk_start = 1'b0;
        while (beats < 11 && cyc < 300) begin
            if (!rk_valid) begin
                chk("stream_valid", rk_valid, 1);
                break;
            end
            if (held) begin
                chk("stall_out", rk_out, h_out);
                chk("stall_round", rk_round, h_rnd);
                chk("stall_last", rk_last, h_last);
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy) begin
                er = 10 - beats;
                chk("round", rk_round, er);
                chk("key", rk_out, mk(er));
                chk("last", rk_last, er == 0);
                got_keys[beats] = rk_out;
                beats++;
            end
            held = !rdy;
            h_out = rk_out;
            h_rnd = rk_round;
            h_last = rk_last;
            rk_ready = rdy;
            @(posedge clk); #1;
            cyc++;
        end
        rk_ready = 1'b0;
        chk("beats", beats, 11);
        if (!rnd) chk("no_bubbles", cyc, 11);
        chk("end_valid", rk_valid, 0);
        chk("end_keys_ready", keys_ready, 1);
    endtask

    logic [127:0] k;

    initial begin
        build_sbox();

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_last", rk_last, 0);
        chk("rst_out", rk_out, 0);
        chk("rst_round", rk_round, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        rk_start = 1'b1;
        @(posedge clk); #1;
        rk_start = 1'b0;
        chk("start_in_idle", rk_valid, 0);

        // Standard vector, full-rate stream
        load_wait(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        run_stream(1'b0);
        chk("tv1_r10", got_keys[0],
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifndef AES_INV_KEY_MIXCOL_EN
        chk("tv1_r1", got_keys[9],
            128'ha0fafe1788542cb123a339392a6c7605);
`endif
        chk("tv1_r0", got_keys[10],
            128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int i = 0; i < 11; i++) first_run[i] = got_keys[i];

        // Same schedule replayed with random back-pressure
        run_stream(1'b1);
        for (int i = 0; i < 11; i++)
            chk("replay", got_keys[i], first_run[i]);

        load_wait(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        run_stream(1'b0);
        chk("tv2_r10", got_keys[0],
            128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Restart at round 5
        rk_start = 1'b1;
        @(posedge clk); #1;
        rk_start = 1'b0;
        rk_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(posedge clk); #1;
        end
        chk("pre_restart_round", rk_round, 5);
        rk_start = 1'b1;
        @(posedge clk); #1;
        rk_start = 1'b0;
        rk_ready = 1'b0;
        chk("restart_valid", rk_valid, 1);
        chk("restart_round", rk_round, 10);
        chk("restart_key", rk_out, mk(10));
        run_stream(1'b1);

        // key_load (with rk_start) aborts a stream mid-way
        rk_start = 1'b1;
        @(posedge clk); #1;
        rk_ready = 1'b1;
        rk_start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
        end
        chk("pre_abort_round", rk_round, 7);
        rk_start = 1'b1;
        k = {$urandom, $urandom, $urandom, $urandom};
        load_wait(k, 1'b0);
        run_stream(1'b1);

        // Reset pulse in the middle of an expansion
        k = {$urandom, $urandom, $urandom, $urandom};
        key_in = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        for (int c = 0; c < 19; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_keys_ready", keys_ready, 0);
        chk("arst_valid", rk_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_keys_ready", keys_ready, 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        load_wait(k, 1'b0);
        run_stream(1'b1);

        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            load_wait(k, 1'b1);
            run_stream(1'b1);
            run_stream(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
